// File: rtl/ram_controller.sv
// Multicycle data-memory controller with an MFA/MOC handshake.
// Byte-addressed big-endian array; byte/halfword/word accesses with optional
// sign extension on loads. Misaligned or out-of-range requests are rejected
// with align_err instead of touching the array.
module ram_controller #(
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mfa,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic        unsign,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        moc,
  output logic        busy,
  output logic        align_err
);

  localparam int unsigned CntW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} ctrlState;

  ctrlState          state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] addrQ;
  logic [31:0]       dataQ;
  logic              rwQ;
  logic              unsignQ;
  logic              errQ;
  logic [1:0]        sizeQ;
  logic [CntW-1:0]   cnt;

  logic              reqIllegal;
  logic              doAccess;
  logic [7:0]        b0, b1, b2, b3;
  logic              extBit;
  logic [31:0]       loadVal;

  // Legality of the request presented on the bus this cycle.
  assign reqIllegal = (addr[31:ADDR_W] != '0) ||
                      (size == 2'b11) ||
                      ((size == 2'b01) && addr[0]) ||
                      ((size == 2'b10) && (addr[1:0] != 2'b00));

  // Last WAIT edge of a legal request: the access happens here.
  assign doAccess = (state == StWait) && !errQ && (cnt == CntW'(1));

  // Big-endian gather and load extension from the latched request.
  always_comb begin
    b0      = mem[addrQ];
    b1      = mem[addrQ + ADDR_W'(1)];
    b2      = mem[addrQ + ADDR_W'(2)];
    b3      = mem[addrQ + ADDR_W'(3)];
    extBit  = 1'b0;
    loadVal = {b0, b1, b2, b3};
    case (sizeQ)
      2'b00: begin
        extBit  = b0[7] & ~unsignQ;
        loadVal = {{24{extBit}}, b0};
      end
      2'b01: begin
        extBit  = b0[7] & ~unsignQ;
        loadVal = {{16{extBit}}, b0, b1};
      end
      default: loadVal = {b0, b1, b2, b3};
    endcase
  end

  // Array writes; contents survive reset, and nothing commits while reset is high.
  always_ff @(posedge clk) begin
    if (!reset && doAccess && !rwQ) begin
      case (sizeQ)
        2'b00: mem[addrQ] <= dataQ[7:0];
        2'b01: begin
          mem[addrQ]               <= dataQ[15:8];
          mem[addrQ + ADDR_W'(1)]  <= dataQ[7:0];
        end
        2'b10: begin
          mem[addrQ]               <= dataQ[31:24];
          mem[addrQ + ADDR_W'(1)]  <= dataQ[23:16];
          mem[addrQ + ADDR_W'(2)]  <= dataQ[15:8];
          mem[addrQ + ADDR_W'(3)]  <= dataQ[7:0];
        end
        default: ;
      endcase
    end
  end

  // Handshake FSM with registered outputs. Illegal requests still pass through
  // WAIT for one edge so that the error reply arrives one edge after acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      moc       <= 1'b0;
      busy      <= 1'b0;
      align_err <= 1'b0;
      data_out  <= '0;
      cnt       <= '0;
      addrQ     <= '0;
      dataQ     <= '0;
      rwQ       <= 1'b0;
      unsignQ   <= 1'b0;
      sizeQ     <= 2'b00;
      errQ      <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (mfa) begin
            addrQ   <= addr[ADDR_W-1:0];
            dataQ   <= data_in;
            rwQ     <= rw;
            sizeQ   <= size;
            unsignQ <= unsign;
            errQ    <= reqIllegal;
            cnt     <= CntW'(LATENCY);
            busy    <= 1'b1;
            state   <= StWait;
          end
        end
        StWait: begin
          if (errQ) begin
            moc       <= 1'b1;
            align_err <= 1'b1;
            state     <= StDone;
          end else begin
            cnt <= cnt - CntW'(1);
            if (cnt == CntW'(1)) begin
              moc       <= 1'b1;
              align_err <= 1'b0;
              if (rwQ) data_out <= loadVal;
              state     <= StDone;
            end
          end
        end
        StDone: begin
          if (!mfa) begin
            moc       <= 1'b0;
            align_err <= 1'b0;
            busy      <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_controller.sv
// Directed self-checking bench for ram_controller (LATENCY=2).
module tb_ram_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        mfa;
  logic        rw;
  logic [1:0]  size;
  logic        unsign;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        moc;
  logic        busy;
  logic        align_err;

  int checks   = 0;
  int failures = 0;

  ram_controller #(.DEPTH(512), .ADDR_W(9), .LATENCY(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .mfa       (mfa),
    .rw        (rw),
    .size      (size),
    .unsign    (unsign),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .moc       (moc),
    .busy      (busy),
    .align_err (align_err)
  );

  always #5 clk = ~clk;

  // Issue one request; lat = edges after E0 until moc is seen (20 = timeout).
  // Bus fields are scrambled after E0 to show they are not re-sampled.
  task automatic do_req(input logic rwI, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic err, output logic [31:0] dout);
    @(negedge clk);
    mfa = 1'b1; rw = rwI; size = sz; unsign = un; addr = a; data_in = d;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    addr = 32'h0000_0100; data_in = 32'h5555_5555; rw = ~rwI; size = 2'b00; unsign = ~un;
    while (!moc && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    err  = align_err;
    dout = data_out;
    mfa  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; mfa = 1'b0; rw = 1'b0; size = 2'b00; unsign = 1'b0;
    addr = '0; data_in = '0;
    repeat (2) @(negedge clk);
    checks++; if (data_out !== 32'h0) begin failures++;
      $display("FAIL reset_data_out got=%h exp=%h", data_out, 32'h0); end
    checks++; if ({moc, busy, align_err} !== 3'b000) begin failures++;
      $display("FAIL reset_flags got=%b exp=%b", {moc, busy, align_err}, 3'b000); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word;
    int lat; logic err; logic [31:0] d;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, err, d);
    checks++; if (lat != 2 || err !== 1'b0) begin failures++;
      $display("FAIL word_store_lat got=%0d/%b exp=2/0", lat, err); end
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, lat, err, d);
    checks++; if (lat != 2 || d !== 32'hDEAD_BEEF) begin failures++;
      $display("FAIL word_load got=%h lat=%0d exp=deadbeef lat=2", d, lat); end
    do_req(1'b1, 2'b00, 1'b1, 32'h10, 32'h0, lat, err, d);
    checks++; if (d !== 32'h0000_00DE) begin failures++;
      $display("FAIL byte_msb got=%h exp=%h", d, 32'h0000_00DE); end
    do_req(1'b1, 2'b00, 1'b1, 32'h13, 32'h0, lat, err, d);
    checks++; if (d !== 32'h0000_00EF) begin failures++;
      $display("FAIL byte_lsb got=%h exp=%h", d, 32'h0000_00EF); end
  endtask

  task automatic test_byte_ext;
    int lat; logic err; logic [31:0] d;
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h80FF_7F01, lat, err, d);
    do_req(1'b1, 2'b00, 1'b0, 32'h20, 32'h0, lat, err, d);
    checks++; if (d !== 32'hFFFF_FF80) begin failures++;
      $display("FAIL byte_signed got=%h exp=%h", d, 32'hFFFF_FF80); end
    do_req(1'b1, 2'b00, 1'b1, 32'h20, 32'h0, lat, err, d);
    checks++; if (d !== 32'h0000_0080) begin failures++;
      $display("FAIL byte_unsigned got=%h exp=%h", d, 32'h0000_0080); end
    do_req(1'b1, 2'b00, 1'b0, 32'h22, 32'h0, lat, err, d);
    checks++; if (d !== 32'h0000_007F) begin failures++;
      $display("FAIL byte_signed_pos got=%h exp=%h", d, 32'h0000_007F); end
    do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h0, lat, err, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++;
      $display("FAIL byte_signed_ff got=%h exp=%h", d, 32'hFFFF_FFFF); end
  endtask

  task automatic test_narrow;
    int lat; logic err; logic [31:0] d;
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'hAAAA_AAAA, lat, err, d);
    do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'hFFFF_1234, lat, err, d);
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, lat, err, d);
    checks++; if (d !== 32'hAAAA_1234) begin failures++;
      $display("FAIL half_store got=%h exp=%h", d, 32'hAAAA_1234); end
    do_req(1'b0, 2'b00, 1'b0, 32'h21, 32'h1234_565A, lat, err, d);
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, lat, err, d);
    checks++; if (d !== 32'hAA5A_1234) begin failures++;
      $display("FAIL byte_store got=%h exp=%h", d, 32'hAA5A_1234); end
    do_req(1'b0, 2'b01, 1'b0, 32'h40, 32'h0000_8001, lat, err, d);
    do_req(1'b1, 2'b01, 1'b0, 32'h40, 32'h0, lat, err, d);
    checks++; if (d !== 32'hFFFF_8001) begin failures++;
      $display("FAIL half_signed got=%h exp=%h", d, 32'hFFFF_8001); end
    do_req(1'b1, 2'b01, 1'b1, 32'h40, 32'h0, lat, err, d);
    checks++; if (d !== 32'h0000_8001) begin failures++;
      $display("FAIL half_unsigned got=%h exp=%h", d, 32'h0000_8001); end
  endtask

  task automatic test_errors;
    int lat; logic err; logic [31:0] d;
    logic        eRw   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  eSize [5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b10};
    logic [31:0] eAddr [5] = '{32'h21, 32'h23, 32'h20, 32'h200, 32'h21};
    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0102_0304, lat, err, d);
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, lat, err, d);
    for (int i = 0; i < 5; i++) begin
      do_req(eRw[i], eSize[i], 1'b0, eAddr[i], 32'hCAFE_F00D, lat, err, d);
      checks++; if (lat != 1 || err !== 1'b1 || d !== 32'hAA5A_1234) begin failures++;
        $display("FAIL err_case%0d got lat=%0d err=%b dout=%h exp lat=1 err=1 dout=aa5a1234",
                 i, lat, err, d); end
    end
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, lat, err, d);
    checks++; if (d !== 32'hAA5A_1234 || err !== 1'b0) begin failures++;
      $display("FAIL err_array_20 got=%h exp=%h", d, 32'hAA5A_1234); end
    do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h0, lat, err, d);
    checks++; if (d !== 32'h0102_0304) begin failures++;
      $display("FAIL err_array_00 got=%h exp=%h", d, 32'h0102_0304); end
  endtask

  task automatic test_reset_midop;
    int lat; logic err; logic [31:0] d;
    int n;
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, lat, err, d);
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, lat, err, d);
    @(negedge clk);
    mfa = 1'b1; rw = 1'b0; size = 2'b10; unsign = 1'b0; addr = 32'h30; data_in = 32'h1111_1111;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++;
      $display("FAIL busy_after_e0 got=%b exp=1", busy); end
    reset = 1'b1;
    #1;
    checks++; if ({moc, busy, align_err} !== 3'b000 || data_out !== 32'h0) begin failures++;
      $display("FAIL async_reset got flags=%b dout=%h exp 000/0", {moc, busy, align_err},
               data_out); end
    mfa = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h0, lat, err, d);
    checks++; if (d !== 32'h0) begin failures++;
      $display("FAIL wait_write_dropped got=%h exp=%h", d, 32'h0); end
    // Reset while in DONE: the write already happened.
    @(negedge clk);
    mfa = 1'b1; rw = 1'b0; size = 2'b10; addr = 32'h34; data_in = 32'h2222_2222;
    n = 0;
    @(negedge clk);
    while (!moc && n < 20) begin @(negedge clk); n++; end
    reset = 1'b1; #1; mfa = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    do_req(1'b1, 2'b10, 1'b0, 32'h34, 32'h0, lat, err, d);
    checks++; if (d !== 32'h2222_2222) begin failures++;
      $display("FAIL done_write_kept got=%h exp=%h", d, 32'h2222_2222); end
  endtask

  task automatic test_handshake;
    int n;
    logic held;
    @(negedge clk);
    mfa = 1'b1; rw = 1'b1; size = 2'b10; unsign = 1'b0; addr = 32'h10;
    n = 0;
    @(negedge clk);
    while (!moc && n < 20) begin @(negedge clk); n++; end
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (moc !== 1'b1) held = 1'b0;
    end
    checks++; if (held !== 1'b1 || data_out !== 32'hDEAD_BEEF) begin failures++;
      $display("FAIL moc_held got=%b dout=%h exp=1 deadbeef", held, data_out); end
    mfa = 1'b0;
    @(negedge clk);
    checks++; if ({moc, busy} !== 2'b00) begin failures++;
      $display("FAIL release got=%b exp=00", {moc, busy}); end
    // Re-raise at once: Ed+1 samples it in IDLE.
    mfa = 1'b1; addr = 32'h20; size = 2'b10;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++;
      $display("FAIL rerequest_busy got=%b exp=1", busy); end
    // Drop mfa early while in WAIT: access still completes, moc pulses once.
    mfa = 1'b0;
    @(negedge clk);
    checks++; if (moc !== 1'b0) begin failures++;
      $display("FAIL early_drop_wait got=%b exp=0", moc); end
    @(negedge clk);
    checks++; if (moc !== 1'b1 || data_out !== 32'hAA5A_1234) begin failures++;
      $display("FAIL early_drop_done got=%b dout=%h exp=1 aa5a1234", moc, data_out); end
    @(negedge clk);
    checks++; if ({moc, busy} !== 2'b00) begin failures++;
      $display("FAIL early_drop_idle got=%b exp=00", {moc, busy}); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_ext();
    test_narrow();
    test_errors();
    test_reset_midop();
    test_handshake();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
